pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Front-of-pipeline stall/flush sequencer: load-use interlock, taken-branch
// flush counter and call/return sequencing FSM driving the IF/ID controls.
module pipe_hazard_ctrl #(
    parameter logic [3:0]  OP_LW     = 4'h8,
    parameter logic [3:0]  OP_CALL   = 4'hD,
    parameter logic [3:0]  OP_RET    = 4'hE,
    parameter logic [3:0]  OP_HLT    = 4'hF,
    parameter int unsigned RET_LAT   = 3,
    parameter int unsigned FLUSH_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] id_instr,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_dst_reg,
    input  logic        ex_branch_taken,
    output logic        data_hazard,
    output logic        PC_hazard,
    output logic        call,
    output logic        ret_control,
    output logic        ret_PC,
    output logic        pc_write,
    output logic        busy
);

    if (RET_LAT < 1 || RET_LAT > 7 || FLUSH_LEN < 1 || FLUSH_LEN > 3 ||
        OP_LW == OP_CALL || OP_LW == OP_RET || OP_LW == OP_HLT ||
        OP_CALL == OP_RET || OP_CALL == OP_HLT || OP_RET == OP_HLT) begin : g_param_check
        $error("pipe_hazard_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALL,
        S_RET_WAIT,
        S_RET_DONE
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_LEN);
    localparam logic [2:0] RET_LOAD   = 3'(RET_LAT - 1);

    state_t     state, state_nxt;
    logic [1:0] flush_cnt, flush_cnt_nxt;
    logic [2:0] ret_cnt, ret_cnt_nxt;

    logic [3:0] op, rs, rt;
    logic       unused_rd;
    logic       in_idle;
    logic       flush_active;
    logic       br_accept;
    logic       ctrl_op;

    assign op        = id_instr[15:12];
    assign rs        = id_instr[7:4];
    assign rt        = id_instr[3:0];
    assign unused_rd = ^id_instr[11:8];

    assign in_idle      = (state == S_IDLE);
    assign flush_active = (flush_cnt != '0);
    // The return is older than anything in EX, so a branch is only honoured in IDLE.
    assign br_accept    = ex_branch_taken & in_idle;
    assign ctrl_op      = (op == OP_CALL) | (op == OP_RET) | (op == OP_HLT);

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        ret_cnt_nxt   = ret_cnt;

        if (br_accept) begin
            flush_cnt_nxt = FLUSH_LOAD;
        end else if (flush_active) begin
            flush_cnt_nxt = flush_cnt - 2'd1;
        end

        case (state)
            S_IDLE: begin
                // A same-cycle branch or a running flush makes the decoded call/return wrong-path.
                if (!ex_branch_taken && !flush_active) begin
                    if (op == OP_CALL) begin
                        state_nxt = S_CALL;
                    end else if (op == OP_RET) begin
                        state_nxt   = S_RET_WAIT;
                        ret_cnt_nxt = RET_LOAD;
                    end
                end
            end
            S_CALL: begin
                state_nxt = S_IDLE;
            end
            S_RET_WAIT: begin
                if (ret_cnt == '0) begin
                    state_nxt = S_RET_DONE;
                end else begin
                    ret_cnt_nxt = ret_cnt - 3'd1;
                end
            end
            S_RET_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            ret_cnt   <= ret_cnt_nxt;
        end
    end

    assign data_hazard = ex_mem_read & (ex_dst_reg != '0) &
                         ((ex_dst_reg == rs) | (ex_dst_reg == rt)) &
                         ~ctrl_op & in_idle & ~flush_active;

    assign PC_hazard   = flush_active;
    assign call        = (state == S_CALL);
    assign ret_control = (state == S_RET_WAIT);
    assign ret_PC      = (state == S_RET_DONE);
    assign pc_write    = ~(data_hazard | call | ret_control);
    assign busy        = ~in_idle | flush_active;

endmodule
